// File: rtl/rxd_pkg.sv
// Shared definitions for the rxd data bus: address map of the decoded slave
// regions and the observable state bundle of the multi-master arbiter.
package rxd_pkg;

    localparam int DATA_BUS_NUM_MASTERS = 2;
    localparam int DATA_BUS_NUM_SLAVES  = 8;
    localparam int DATA_BUS_ADDR_WIDTH  = 32;
    localparam int DATA_BUS_MI_W        = (DATA_BUS_NUM_MASTERS > 1) ? $clog2(DATA_BUS_NUM_MASTERS) : 1;

    localparam int SLV_CODE_RAM = 0;
    localparam int SLV_DATA_RAM = 1;
    localparam int SLV_UART     = 2;
    localparam int SLV_TIMER    = 3;
    localparam int SLV_GPIO     = 4;
    localparam int SLV_PERIPH   = 5;
    localparam int SLV_BOOT_ROM = 6;
    localparam int SLV_DEBUG    = 7;

    // PERIPH is a catch-all window over the whole peripheral space, so it
    // overlaps UART/TIMER/GPIO; the lower-indexed specific slave wins.
    localparam logic [DATA_BUS_NUM_SLAVES-1:0][DATA_BUS_ADDR_WIDTH-1:0] DATA_BUS_SLAVE_BASE = {
        32'h8000_0000,  // 7 DEBUG
        32'h2000_0000,  // 6 BOOT_ROM
        32'h4000_0000,  // 5 PERIPH
        32'h4000_3000,  // 4 GPIO
        32'h4000_2000,  // 3 TIMER
        32'h4000_1000,  // 2 UART
        32'h1000_0000,  // 1 DATA_RAM
        32'h0000_0000   // 0 CODE_RAM
    };

    localparam logic [DATA_BUS_NUM_SLAVES-1:0][DATA_BUS_ADDR_WIDTH-1:0] DATA_BUS_SLAVE_MASK = {
        32'hFFFF_F000,
        32'hFFFF_0000,
        32'hFFF0_0000,
        32'hFFFF_F000,
        32'hFFFF_F000,
        32'hFFFF_F000,
        32'hFFFF_0000,
        32'hFFFF_0000
    };

    typedef struct packed {
        logic [DATA_BUS_NUM_SLAVES-1:0] requested_slave;
        logic [DATA_BUS_NUM_SLAVES-1:0] responding_slave;
        logic [DATA_BUS_MI_W-1:0]       responding_master;
        logic                           rsp_valid;
        logic                           decode_err;
    } data_bus_mm_state_t;

endpackage

// File: rtl/data_bus_mm_arbiter_rr_arbiter.sv
// Round-robin arbiter with per-requester bus lock. The grant is combinational;
// the round-robin pointer and lock owner are registered.
module rr_arbiter
    import rxd_pkg::*;
#(
    parameter int NUM_REQ = 2,
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] lock,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IW-1:0]      gnt_idx,
    output logic               gnt_any
);

    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] lock_owner;
    logic          lock_owner_valid;
    logic          lock_hold;

    // Dropping either m_lock or m_req releases the lock in the same cycle.
    assign lock_hold = lock_owner_valid && req[lock_owner] && lock[lock_owner];

    always_comb begin
        gnt_any = |req;
        gnt_idx = '0;
        if (lock_hold) begin
            gnt_idx = lock_owner;
        end else begin
            // Two descending passes: the later pass (indices at or above the
            // pointer) overrides, leaving the lowest index in the winning half.
            for (int j = NUM_REQ - 1; j >= 0; j--) begin
                if (req[j] && (j < int'(rr_ptr))) gnt_idx = IW'(j);
            end
            for (int j = NUM_REQ - 1; j >= 0; j--) begin
                if (req[j] && (j >= int'(rr_ptr))) gnt_idx = IW'(j);
            end
        end
    end

    always_comb begin
        gnt = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            gnt[j] = gnt_any && (gnt_idx == IW'(j));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr           <= '0;
            lock_owner       <= '0;
            lock_owner_valid <= 1'b0;
        end else begin
            if (gnt_any) begin
                rr_ptr <= (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + IW'(1);
            end
            lock_owner_valid <= gnt_any && lock[gnt_idx];
            if (gnt_any && lock[gnt_idx]) begin
                lock_owner <= gnt_idx;
            end
        end
    end

endmodule

// File: rtl/data_bus_mm_arbiter.sv
// Multi-master data bus: round-robin/lock arbitration, base/mask slave decode
// and a one-cycle response pipeline routing slave and master back.
module data_bus_mm_arbiter
    import rxd_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int NUM_SLAVES  = 8,
    parameter int ADDR_WIDTH  = 32,
    parameter logic [NUM_SLAVES-1:0][ADDR_WIDTH-1:0] SLAVE_BASE = '0,
    parameter logic [NUM_SLAVES-1:0][ADDR_WIDTH-1:0] SLAVE_MASK = '1,
    localparam int MI_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_MASTERS-1:0]            m_req,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
    input  logic [NUM_MASTERS-1:0]            m_lock,
    output logic [NUM_MASTERS-1:0]            m_gnt,
    output logic [ADDR_WIDTH-1:0]             bus_addr,
    output logic [NUM_SLAVES-1:0]             requested_slave,
    output logic [NUM_SLAVES-1:0]             responding_slave,
    output logic [MI_W-1:0]                   responding_master,
    output logic                              rsp_valid,
    output logic                              decode_err
);

    logic [MI_W-1:0] gnt_idx;
    logic            gnt_any;
    logic            slave_hit;

    rr_arbiter #(
        .NUM_REQ (NUM_MASTERS)
    ) u_rr_arbiter (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (m_req),
        .lock    (m_lock),
        .gnt     (m_gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    always_comb begin
        bus_addr = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (m_gnt[k]) bus_addr = m_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    // Address 0 decodes to a real region, so the select is gated by the grant.
    always_comb begin
        requested_slave = '0;
        slave_hit       = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (!slave_hit && gnt_any && ((bus_addr & SLAVE_MASK[i]) == SLAVE_BASE[i])) begin
                requested_slave[i] = 1'b1;
                slave_hit          = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            responding_slave  <= '0;
            responding_master <= '0;
            rsp_valid         <= 1'b0;
            decode_err        <= 1'b0;
        end else begin
            responding_slave  <= requested_slave;
            responding_master <= gnt_idx;
            rsp_valid         <= gnt_any;
            decode_err        <= gnt_any && !slave_hit;
        end
    end

endmodule
